// File: rtl/vio_pkg.sv
// vio_pkg: register map, CTRL fields and seven-segment decode shared by mmio_vio.
package vio_pkg;
  localparam logic [7:0] OFF_LED_LO    = 8'h00;
  localparam logic [7:0] OFF_LED_HI    = 8'h04;
  localparam logic [7:0] OFF_SW_LO     = 8'h08;
  localparam logic [7:0] OFF_SW_HI     = 8'h0C;
  localparam logic [7:0] OFF_BTN_STATE = 8'h10;
  localparam logic [7:0] OFF_BTN_EDGE  = 8'h14;
  localparam logic [7:0] OFF_BTN_IEN   = 8'h18;
  localparam logic [7:0] OFF_SEG_LO    = 8'h1C;
  localparam logic [7:0] OFF_SEG_HI    = 8'h20;
  localparam logic [7:0] OFF_CTRL      = 8'h24;
  localparam logic [7:0] OFF_HEX       = 8'h28;
  localparam int CTRL_HEXMODE = 0;
  localparam int CTRL_DP_LSB  = 8;
  localparam logic [31:0] CTRL_MASK = 32'h0000_FF01;
  localparam logic [6:0] HEX7SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  function automatic logic [6:0] hex7seg(input logic [3:0] n);
    return HEX7SEG[n];
  endfunction
endpackage

// File: rtl/vio_debounce.sv
// vio_debounce: two-flop synchroniser plus stability counter for one button.
module vio_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic state
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic differ;
  assign differ = sync[1] != state;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      state <= 1'b0;
    end else begin
      sync  <= {sync[0], din};
      cnt   <= !differ || cnt == LAST ? '0 : cnt + CW'(1);
      state <= differ && cnt == LAST ? sync[1] : state;
    end
  end
endmodule

// File: rtl/mmio_vio.sv
// mmio_vio: memory-mapped virtual LED/switch/button/seven-segment peripheral.
module mmio_vio
  import vio_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 32,
  parameter logic [ADDRWIDTH-1:0] BASE_ADDR = 'hFFFF_FF00,
  parameter int N_LED = 36,
  parameter int N_SW = 36,
  parameter int N_BTN = 20,
  parameter int N_SSLED = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 iClk,
  input  logic                 iReset,
  input  logic [ADDRWIDTH-1:0] iAB,
  input  logic                 iWR,
  input  logic                 iRD,
  input  logic [DATAWIDTH-1:0] iWriteData,
  output logic [DATAWIDTH-1:0] oReadData,
  output logic                 oSel,
  input  logic [N_SW-1:0]      iSWITCH,
  input  logic [N_BTN-1:0]     iBUTTON,
  output logic [N_LED-1:0]     oLED,
  output logic [8*N_SSLED-1:0] oSSLED,
  output logic                 oIrq
);
  localparam logic [63:0] LED_MASK = (64'd1 << N_LED) - 64'd1;
  logic [7:0] off;
  logic wr, rd, unused;
  logic [31:0] wd, rdata, hex_q, hex_n, ctrl_q, ctrl_n;
  logic [63:0] led_q, led_n, seg_q, seg_n, sw64;
  logic [N_BTN-1:0] btn_state, btn_prev, rise, clr, edge_q, edge_n, ien_q, ien_n;
  logic [8*N_SSLED-1:0] disp;
  assign oSel   = iAB[ADDRWIDTH-1:8] == BASE_ADDR[ADDRWIDTH-1:8];
  assign off    = {iAB[7:2], 2'b00};
  assign wr     = iWR && oSel;
  assign rd     = iRD && oSel;
  assign wd     = iWriteData;
  assign sw64   = 64'(iSWITCH);
  assign oLED   = led_q[N_LED-1:0];
  assign unused = ^iAB[1:0];
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    vio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (iClk),
      .rst  (iReset),
      .din  (iBUTTON[i]),
      .state(btn_state[i])
    );
  end
  // The display is driven from next-state values so it tracks LED timing.
  always_comb begin
    led_n  = LED_MASK & (wr && off == OFF_LED_LO ? {led_q[63:32], wd} :
                         wr && off == OFF_LED_HI ? {wd, led_q[31:0]} : led_q);
    seg_n  = wr && off == OFF_SEG_LO ? {seg_q[63:32], wd} :
             wr && off == OFF_SEG_HI ? {wd, seg_q[31:0]} : seg_q;
    hex_n  = wr && off == OFF_HEX ? wd : hex_q;
    ctrl_n = wr && off == OFF_CTRL ? wd & CTRL_MASK : ctrl_q;
    ien_n  = wr && off == OFF_BTN_IEN ? wd[N_BTN-1:0] : ien_q;
    clr    = wr && off == OFF_BTN_EDGE ? wd[N_BTN-1:0] : '0;
    rise   = btn_state & ~btn_prev;
    edge_n = (edge_q & ~clr) | rise;
    disp   = '0;
    for (int k = 0; k < N_SSLED; k++)
      disp[8*k+:8] = ctrl_n[CTRL_HEXMODE] ? {ctrl_n[CTRL_DP_LSB+k], hex7seg(hex_n[4*k+:4])}
                                          : seg_n[8*k+:8];
  end
  always_comb begin
    case (off)
      OFF_LED_LO:    rdata = led_q[31:0];
      OFF_LED_HI:    rdata = led_q[63:32];
      OFF_SW_LO:     rdata = sw64[31:0];
      OFF_SW_HI:     rdata = sw64[63:32];
      OFF_BTN_STATE: rdata = 32'(btn_state);
      OFF_BTN_EDGE:  rdata = 32'(edge_q);
      OFF_BTN_IEN:   rdata = 32'(ien_q);
      OFF_SEG_LO:    rdata = seg_q[31:0];
      OFF_SEG_HI:    rdata = seg_q[63:32];
      OFF_CTRL:      rdata = ctrl_q;
      OFF_HEX:       rdata = hex_q;
      default:       rdata = '0;
    endcase
  end
  always_ff @(posedge iClk) begin
    if (iReset) begin
      led_q     <= '0;
      seg_q     <= '0;
      hex_q     <= '0;
      ctrl_q    <= '0;
      ien_q     <= '0;
      edge_q    <= '0;
      btn_prev  <= '0;
      oSSLED    <= '0;
      oIrq      <= 1'b0;
      oReadData <= '0;
    end else begin
      led_q     <= led_n;
      seg_q     <= seg_n;
      hex_q     <= hex_n;
      ctrl_q    <= ctrl_n;
      ien_q     <= ien_n;
      edge_q    <= edge_n;
      btn_prev  <= btn_state;
      oSSLED    <= disp;
      oIrq      <= |(edge_q & ien_q);
      oReadData <= rd ? rdata : oReadData;
    end
  end
endmodule

// File: tb/tb_mmio_vio.sv
// tb_mmio_vio: randomized scoreboard bench for mmio_vio against a register-level model.
module tb_mmio_vio;
  localparam int NL = 36, NS = 36, NB = 20, NSS = 8, DC = 4;
  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  logic clk = 1'b0, rst = 1'b1, wr = 1'b0, rd = 1'b0, sel, irq;
  logic [31:0] ab = '0, wdata = '0, rdata;
  logic [NS-1:0] sw = '0;
  logic [NB-1:0] btn = '0;
  logic [NL-1:0] led;
  logic [8*NSS-1:0] ss;
  int checks = 0, failures = 0;
  bit started = 0;

  always #5 clk = ~clk;

  mmio_vio #(.N_LED(NL), .N_SW(NS), .N_BTN(NB), .N_SSLED(NSS), .DEBOUNCE_CYCLES(DC)) dut (
    .iClk(clk), .iReset(rst), .iAB(ab), .iWR(wr), .iRD(rd), .iWriteData(wdata),
    .oReadData(rdata), .oSel(sel), .iSWITCH(sw), .iBUTTON(btn), .oLED(led),
    .oSSLED(ss), .oIrq(irq)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: register contents plus "level held for DC synced cycles" debounce.
  logic [6:0] seg7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [63:0] m_led, m_seg;
  logic [31:0] m_hex, m_ctrl;
  logic [NB-1:0] m_ien, m_edge, m_btn, m_rose;
  logic m_irq;
  logic [NB-1:0] hist [DC+2];
  logic [31:0] exp_q [$];

  function automatic logic [31:0] model_read(input logic [7:0] o);
    case (o)
      8'h00: return m_led[31:0];
      8'h04: return m_led[63:32];
      8'h08: return sw[31:0];
      8'h0C: return {28'h0, sw[35:32]};
      8'h10: return 32'(m_btn);
      8'h14: return 32'(m_edge);
      8'h18: return 32'(m_ien);
      8'h1C: return m_seg[31:0];
      8'h20: return m_seg[63:32];
      8'h24: return m_ctrl;
      8'h28: return m_hex;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [63:0] model_disp();
    logic [63:0] r;
    for (int k = 0; k < 8; k++)
      r[8*k+:8] = m_ctrl[0] ? {m_ctrl[8+k], seg7[m_hex[4*k+:4]]} : m_seg[8*k+:8];
    return r;
  endfunction

  initial forever begin : model
    logic s, ni;
    logic [7:0] o;
    logic [NB-1:0] clr, and_w, or_w, nb;
    @(posedge clk);
    if (rst) begin
      m_led = '0; m_seg = '0; m_hex = '0; m_ctrl = '0;
      m_ien = '0; m_edge = '0; m_btn = '0; m_rose = '0; m_irq = 1'b0;
      for (int i = 0; i < DC + 2; i++) hist[i] = '0;
    end else begin
      s = ab[31:8] == BASE[31:8];
      o = {ab[7:2], 2'b00};
      if (rd && s) exp_q.push_back(model_read(o));
      ni = |(m_edge & m_ien);
      clr = (wr && s && o == 8'h14) ? wdata[NB-1:0] : '0;
      m_edge = (m_edge & ~clr) | m_rose;
      for (int i = DC + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = btn;
      and_w = '1;
      or_w = '0;
      for (int i = 2; i < DC + 2; i++) begin
        and_w &= hist[i];
        or_w |= hist[i];
      end
      nb = (m_btn & or_w) | and_w;
      m_rose = nb & ~m_btn;
      m_btn = nb;
      if (wr && s)
        case (o)
          8'h00: m_led[31:0] = wdata;
          8'h04: m_led[63:32] = wdata;
          8'h18: m_ien = wdata[NB-1:0];
          8'h1C: m_seg[31:0] = wdata;
          8'h20: m_seg[63:32] = wdata;
          8'h24: m_ctrl = wdata & 32'h0000_FF01;
          8'h28: m_hex = wdata;
          default: ;
        endcase
      m_led &= 64'hF_FFFF_FFFF;
      m_irq = ni;
    end
  end

  initial forever begin : read_monitor
    @(posedge clk);
    if (!rst && rd && ab[31:8] == BASE[31:8]) begin
      @(negedge clk);
      if (exp_q.size() == 0) check("rd_underflow", 64'(exp_q.size()), 64'd1);
      else check("oReadData", 64'(rdata), 64'(exp_q.pop_front()));
    end
  end

  initial forever begin : out_monitor
    @(negedge clk);
    if (started) begin
      check("oLED", 64'(led), m_led);
      check("oSSLED", ss, model_disp());
      check("oIrq", 64'(irq), 64'(m_irq));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr = w; rd = r; ab = a; wdata = d;
    #1 check("oSel", 64'(sel), 64'(a[31:8] == BASE[31:8]));
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, BASE, 0);
  endtask

  initial begin
    logic [31:0] seglo, seghi;
    idle(3);
    rst = 1'b0;
    started = 1;
    check("rst_led", 64'(led), 64'h0);
    check("rst_ss", ss, 64'h0);
    check("rst_irq", 64'(irq), 64'h0);
    check("rst_rdata", 64'(rdata), 64'h0);
    for (int o = 0; o < 64; o += 4) step(0, 1, BASE | 32'(o), 0);
    idle(1);
    // LED write, masked readback
    step(1, 0, BASE | 32'h00, 32'hDEADBEEF);
    step(1, 0, BASE | 32'h04, 32'hFFFFFFFF);
    step(0, 1, BASE | 32'h04, 0);
    check("led_value", 64'(led), 64'hF_DEAD_BEEF);
    idle(1);
    check("led_hi_read", 64'(rdata), 64'h0000_000F);
    // Debounce latency, edge flag, interrupt
    step(1, 0, BASE | 32'h18, 32'h8);
    idle(2);
    step(0, 0, BASE, 0); btn[3] = 1'b1;
    idle(4);
    step(0, 1, BASE | 32'h10, 0);
    step(0, 1, BASE | 32'h10, 0);
    check("btn_before", 64'(rdata), 64'h0);
    step(0, 1, BASE | 32'h14, 0);
    check("btn_at", 64'(rdata), 64'h8);
    check("irq_lag", 64'(irq), 64'h0);
    idle(1);
    check("edge_set", 64'(rdata), 64'h8);
    check("irq_set", 64'(irq), 64'h1);
    // Short glitch is filtered
    step(0, 0, BASE, 0); btn[0] = 1'b1;
    idle(2);
    step(0, 0, BASE, 0); btn[0] = 1'b0;
    idle(8);
    step(0, 1, BASE | 32'h10, 0);
    step(0, 1, BASE | 32'h14, 0);
    check("glitch_state", 64'(rdata), 64'h8);
    idle(1);
    check("glitch_edge", 64'(rdata), 64'h8);
    // Set beats clear on the same cycle
    step(0, 0, BASE, 0); btn[3] = 1'b0;
    idle(8);
    step(0, 0, BASE, 0); btn[3] = 1'b1;
    idle(5);
    step(1, 0, BASE | 32'h14, 32'h8);
    idle(1);
    step(0, 1, BASE | 32'h14, 0);
    idle(1);
    check("set_wins", 64'(rdata), 64'h8);
    step(1, 0, BASE | 32'h14, 32'h8);
    idle(1);
    check("irq_hold", 64'(irq), 64'h1);
    idle(1);
    check("irq_drop", 64'(irq), 64'h0);
    // Display modes
    seglo = $urandom;
    seghi = $urandom;
    step(1, 0, BASE | 32'h1C, seglo);
    step(1, 0, BASE | 32'h20, seghi);
    step(1, 0, BASE | 32'h24, 32'h0000_0101);
    step(1, 0, BASE | 32'h28, 32'h0000_00A5);
    idle(1);
    check("hexmode", ss, 64'h3F3F3F3F_3F3F77ED);
    step(1, 0, BASE | 32'h24, 32'h0);
    idle(1);
    check("rawmode", ss, {seghi, seglo});
    // Reset in the middle of a debounce count
    step(0, 0, BASE, 0); btn[5] = 1'b1;
    idle(3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step(0, 1, BASE | 32'h10, 0);
    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 15) == 0) ? $urandom
                                       : {BASE[31:8], 6'($urandom_range(0, 13)), 2'($urandom)};
      if ($urandom_range(0, 3) == 0) btn[$urandom_range(0, NB - 1)] ^= 1'b1;
      if ($urandom_range(0, 49) == 0) sw = {$urandom, $urandom};
      rst = $urandom_range(0, 599) == 0;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, a, $urandom);
    end
    rst = 1'b0;
    idle(3);
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mmio_vio.md
Name: mmio_vio

Overview:
- Memory-mapped virtual I/O controller on the CPU data bus. It fills the SoC's I/O interface slot and drives the virtual LED, switch, button and seven-segment elements that the on-chip debug boundary scan exposes.
- Generalises the fixed LED/switch/button/SSLED wiring into a parametrised peripheral with:
  - button debounce,
  - sticky edge capture with interrupt,
  - a hex-decode display mode.

Parameters:
- DATAWIDTH, 32, bus data width; fixed at 32.
- ADDRWIDTH, 32, bus address width.
- BASE_ADDR, 32'hFFFF_FF00, peripheral base address. A 256-byte window is decoded on iAB[ADDRWIDTH-1:8].
- N_LED, 36, LED count, 1..64.
- N_SW, 36, switch count, 1..64.
- N_BTN, 20, button count, 1..32.
- N_SSLED, 8, seven-segment digit count, 1..8.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before the debounced button state changes; must be 2 or more.

Ports:
- iClk  in  1  system clock.
- iReset  in  1  synchronous active-high reset.
- iAB  in  ADDRWIDTH  bus byte address.
- iWR  in  1  write strobe, single cycle.
- iRD  in  1  read strobe, single cycle.
- iWriteData  in  DATAWIDTH  write data.
- oReadData  out  DATAWIDTH  registered read data.
- oSel  out  1  combinational; high when iAB is in the window.
- iSWITCH  in  N_SW  switch levels (boundary-scan side).
- iBUTTON  in  N_BTN  raw button levels, asynchronous.
- oLED  out  N_LED  LED drive.
- oSSLED  out  8*N_SSLED  segments. Digit k occupies [8k+7:8k]; bit0=a … bit6=g, bit7=dp; active-high.
- oIrq  out  1  registered interrupt request.

Behaviour:
- Register map. Offset is iAB[7:2]*4. Undefined offsets read 0 and ignore writes. Unused upper bits of any register read 0.
  - 0x00 LED_LO (RW): LED[31:0].
  - 0x04 LED_HI (RW): LED[N_LED-1:32].
  - 0x08 SW_LO (RO).
  - 0x0C SW_HI (RO).
  - 0x10 BTN_STATE (RO): debounced button levels.
  - 0x14 BTN_EDGE (RW1C): sticky rising-edge flags.
  - 0x18 BTN_IEN (RW): interrupt enables.
  - 0x1C SEG_LO (RW): raw segments, digits 3..0.
  - 0x20 SEG_HI (RW): raw segments, digits 7..4.
  - 0x24 CTRL (RW): bit0 HEXMODE; bits[15:8] DP per digit.
  - 0x28 HEX (RW): 8 nibbles, nibble k shown on digit k.
- Access rules:
  - A write takes effect at the clock edge where iWR && oSel.
  - Read: oReadData is valid on the cycle after iRD && oSel and holds until the next qualified read.
  - Read and write to the same register in the same cycle: the read returns the old value.
  - iWR and iRD both high: the write is performed and the read is also served.
- Debounce, per button:
  - The input passes through a 2-flop synchroniser, then a counter.
  - While the synced level differs from the state, the counter increments. When it reaches DEBOUNCE_CYCLES-1 the state takes the synced level and the counter clears.
  - When the synced level equals the state, the counter clears.
  - Latency: a clean input edge appears in BTN_STATE exactly 2+DEBOUNCE_CYCLES cycles later.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Edge capture:
  - A 0→1 transition of the debounced state sets the corresponding BTN_EDGE bit.
  - Writing 1 clears the bit; writing 0 has no effect.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Interrupt: oIrq <= |(BTN_EDGE & BTN_IEN), registered, so it lags the flag by 1 cycle.
- Display:
  - HEXMODE=0: oSSLED = SEG registers.
  - HEXMODE=1: digit k = hex7seg(HEX nibble k), with bit7 = CTRL DP bit k.
  - hex7seg table 0..F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
  - oSSLED is registered: 1 cycle after a register write.
- oLED: registered, updated 1 cycle after the write.
- Reset values:
  - All registers are 0, including synchronisers, debounce counters and state.
  - oLED=0, oSSLED=0, oIrq=0, oReadData=0.
  - A reset mid-debounce discards the pending count.

Decomposition:
- Package vio_pkg holds:
  - register offset constants;
  - CTRL field positions;
  - the hex7seg function/table.
- Sub-module vio_debounce: one bit of synchroniser plus counter, parameter DEBOUNCE_CYCLES. Instantiate it N_BTN times in a generate loop.

Test Plan:
- Reset, then read every offset → all read 0; oLED=0, oSSLED=0, oIrq=0.
- Write LED_LO=32'hDEADBEEF, LED_HI=32'hFFFFFFFF (N_LED=36) → oLED=36'hFDEADBEEF one cycle later; read LED_HI returns 32'h0000000F.
- Raise iBUTTON[3] and hold, DEBOUNCE_CYCLES=4 → BTN_STATE bit3 rises exactly 6 cycles later. Next cycle BTN_EDGE=32'h8. With BTN_IEN=8, oIrq rises one cycle after that.
- Pulse iBUTTON[0] high for 3 cycles → BTN_STATE and BTN_EDGE stay 0.
- With BTN_EDGE bit3 set, write BTN_EDGE=8 in the same cycle as a new debounced rising edge on bit3 → bit3 remains 1. A later write of 8 with no new edge clears it and oIrq drops one cycle later.
- CTRL=32'h0000_0101, HEX=32'h0000_00A5 → digit0=8'hED (6D|dp), digit1=8'h77, digits 2..7=8'h3F. Then write CTRL=0 → oSSLED equals SEG_HI:SEG_LO.
